hazard_controller: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS-subset core (R-type, lw, sw, bne, xori, j). Sits beside the main decoder. Detects load-use hazards and drives the PC and pipeline-register write enables and flushes. Freezes the pipeline on slow data-memory accesses and squashes wrong-path instructions after a taken bne or a j.

---
 rtl/ctrl_pkg.sv | 32 +++
 rtl/sat_counter.sv | 20 ++
 rtl/hazard_controller.sv | 160 ++++++++++++++++
 tb/tb_hazard_controller.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control definitions for the 5-stage MIPS-subset core: opcodes,
// hazard-controller state encoding, PC source select and operand-usage decode.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // Every instruction except j reads rs (unknown opcodes are treated as readers).
  function automatic logic uses_rs(input logic [5:0] op);
    return op != OP_J;
  endfunction

  // Only R-type, sw and bne read rt; xori/lw write it instead.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the controller performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, data-memory freeze with
// timeout, and wrong-path squash after taken bne / j. Outputs are Mealy so
// every hazard response takes effect in the same cycle it is detected.
module hazard_controller
  import ctrl_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int TIMEOUT  = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       pc_sel,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int LU_W   = 3;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [LU_W-1:0]   lu_q, lu_d;
  logic              mem_err_q, mem_err_d;

  logic freeze;
  logic load_use;
  logic lu_active;
  logic stall_inc;
  logic flush_inc;

  assign freeze    = mem_access && !dmem_ready;
  assign load_use  = ex_mem_read && (ex_rt != 5'd0) &&
                     ((uses_rs(id_opcode) && (ex_rt == id_rs)) ||
                      (uses_rt(id_opcode) && (ex_rt == id_rt)));
  // Remaining stall cycles survive a freeze, so the stall resumes afterwards.
  assign lu_active = (lu_q != '0);
  assign mem_err   = mem_err_q;

  // Prioritised hazard response (freeze > branch > load-use > jump) and next state.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    pc_sel      = PC_SEQ;
    state_d     = state_q;
    wait_d      = wait_q;
    lu_d        = lu_q;
    mem_err_d   = mem_err_q;

    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (freeze) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
        mem_err_d = 1'b1;
        wait_d    = '0;
        state_d   = RUN;
      end else begin
        wait_d    = wait_q + WAIT_W'(1);
        state_d   = MEM_WAIT;
      end
    end else begin
      wait_d = '0;
      if (branch_taken) begin
        pc_sel     = PC_BRANCH;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        lu_d       = '0;
        state_d    = RUN;
      end else if (lu_active) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        if (lu_q == LU_W'(1)) begin
          lu_d    = '0;
          state_d = RUN;
        end else begin
          lu_d    = lu_q - LU_W'(1);
          state_d = LU_STALL;
        end
      end else if (load_use) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
        if (LOAD_LAT > 1) begin
          lu_d    = LU_W'(LOAD_LAT - 1);
          state_d = LU_STALL;
        end else begin
          state_d = RUN;
        end
      end else if (id_opcode == OP_J) begin
        pc_sel     = PC_JUMP;
        ifid_flush = 1'b1;
        state_d    = RUN;
      end else begin
        state_d = RUN;
      end
    end
  end

  // Controller state registers; reset abandons any stall or wait in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wait_q    <= '0;
      lu_q      <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      lu_q      <= lu_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign stall_inc = rst_n && !pc_write;
  assign flush_inc = rst_n && ifid_flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller (LOAD_LAT=3, TIMEOUT=8, CNT_W=4).
// The driver applies one directed vector per cycle just after the rising edge
// and queues the hand-computed response; the monitor checks mid-cycle.
module tb_hazard_controller;
  import ctrl_pkg::*;

  logic       clk          = 1'b0;
  logic       rst_n        = 1'b0;
  logic [5:0] id_opcode    = OP_RTYPE;
  logic [4:0] id_rs        = '0;
  logic [4:0] id_rt        = '0;
  logic       ex_mem_read  = 1'b0;
  logic [4:0] ex_rt        = '0;
  logic       branch_taken = 1'b0;
  logic       mem_access   = 1'b0;
  logic       dmem_ready   = 1'b1;

  logic       pc_write, ifid_write, idex_write, exmem_write;
  logic       ifid_flush, idex_flush, mem_err;
  logic [1:0] pc_sel;
  logic [3:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  hazard_controller #(.LOAD_LAT(3), .TIMEOUT(8), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_opcode    (id_opcode),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .mem_access   (mem_access),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .idex_write   (idex_write),
    .exmem_write  (exmem_write),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .pc_sel       (pc_sel),
    .mem_err      (mem_err),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  typedef struct {
    string       name;
    logic [16:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [16:0] act;
  assign act = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush,
                pc_sel, mem_err, stall_cycles, flush_count};

  // en = {pc,ifid,idex,exmem} write enables, fl = {ifid,idex} flushes
  task automatic vec(input string name, input logic rst, input logic [5:0] op,
                     input logic [4:0] rs, input logic [4:0] rt, input logic exmr,
                     input logic [4:0] exrt, input logic br, input logic ma, input logic dr,
                     input logic [3:0] en, input logic [1:0] fl, input logic [1:0] ps,
                     input logic me, input logic [3:0] st, input logic [3:0] fc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n        = rst;
    id_opcode    = op;
    id_rs        = rs;
    id_rt        = rt;
    ex_mem_read  = exmr;
    ex_rt        = exrt;
    branch_taken = br;
    mem_access   = ma;
    dmem_ready   = dr;
    e.name = name;
    e.exp  = {en, fl, ps, me, st, fc};
    sb_q.push_back(e);
  endtask

  task automatic idle(input string name, input logic me, input logic [3:0] st, input logic [3:0] fc);
    vec(name, 1'b1, OP_RTYPE, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
        4'hF, 2'b00, PC_SEQ, me, st, fc);
  endtask

  task automatic rstv(input string name);
    vec(name, 1'b0, OP_RTYPE, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
        4'h0, 2'b11, PC_SEQ, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic stallv(input string name, input logic [3:0] st, input logic [3:0] fc);
    vec(name, 1'b1, OP_RTYPE, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1,
        4'b0011, 2'b01, PC_SEQ, 1'b0, st, fc);
  endtask

  task automatic freezev(input string name, input logic br, input logic me,
                         input logic [3:0] st, input logic [3:0] fc);
    vec(name, 1'b1, OP_RTYPE, 5'd0, 5'd0, 1'b0, 5'd0, br, 1'b1, 1'b0,
        4'h0, 2'b00, PC_SEQ, me, st, fc);
  endtask

  // Monitor: pop one expectation per cycle and compare mid-cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_vec++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: actual en=%b fl=%b pc_sel=%0d err=%b stall=%0d flush=%0d, required en=%b fl=%b pc_sel=%0d err=%b stall=%0d flush=%0d",
                 e.name, act[16:13], act[12:11], act[10:9], act[8], act[7:4], act[3:0],
                 e.exp[16:13], e.exp[12:11], e.exp[10:9], e.exp[8], e.exp[7:4], e.exp[3:0]);
      end
    end
  end

  initial begin
    // Reset, load-use through rs, non-hazards, jump
    rstv("reset");
    idle("release", 1'b0, 4'd0, 4'd0);
    vec("lu_rs", 1'b1, OP_RTYPE, 5'd2, 5'd0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 4'b0011, 2'b01, PC_SEQ, 1'b0, 4'd0, 4'd0);
    stallv("lu_rs_hold1", 4'd1, 4'd0);
    stallv("lu_rs_hold2", 4'd2, 4'd0);
    idle("lu_rs_done", 1'b0, 4'd3, 4'd0);
    vec("xori_rt_no_use", 1'b1, OP_XORI, 5'd0, 5'd2, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 4'hF, 2'b00, PC_SEQ, 1'b0, 4'd3, 4'd0);
    vec("ex_rt_zero", 1'b1, OP_RTYPE, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 4'hF, 2'b00, PC_SEQ, 1'b0, 4'd3, 4'd0);
    vec("jump", 1'b1, OP_J, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'hF, 2'b10, PC_JUMP, 1'b0, 4'd3, 4'd0);
    idle("after_jump", 1'b0, 4'd3, 4'd1);

    // sw rt hazard, branch aborts the stall on its 2nd cycle
    vec("sw_rt", 1'b1, OP_SW, 5'd0, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 4'b0011, 2'b01, PC_SEQ, 1'b0, 4'd3, 4'd1);
    vec("br_abort_lu", 1'b1, OP_RTYPE, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 4'hF, 2'b11, PC_BRANCH, 1'b0, 4'd4, 4'd1);
    idle("after_br_abort", 1'b0, 4'd4, 4'd2);

    // Freeze in the middle of a load-use stall: counter holds then resumes
    vec("lu_fz", 1'b1, OP_RTYPE, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 4'b0011, 2'b01, PC_SEQ, 1'b0, 4'd4, 4'd2);
    freezev("fz_in_lu1", 1'b0, 1'b0, 4'd5, 4'd2);
    freezev("fz_in_lu2", 1'b0, 1'b0, 4'd6, 4'd2);
    stallv("lu_resume1", 4'd7, 4'd2);
    stallv("lu_resume2", 4'd8, 4'd2);
    idle("lu_fz_done", 1'b0, 4'd9, 4'd2);

    // Branch outranks a simultaneous load-use hazard
    vec("br_over_lu", 1'b1, OP_RTYPE, 5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 4'hF, 2'b11, PC_BRANCH, 1'b0, 4'd9, 4'd2);
    idle("after_br_over_lu", 1'b0, 4'd9, 4'd3);

    // Four frozen cycles with branch held, branch acts on the 5th
    rstv("reset2");
    idle("release2", 1'b0, 4'd0, 4'd0);
    for (int k = 0; k < 4; k++) freezev($sformatf("freeze_br%0d", k), 1'b1, 1'b0, 4'(k), 4'd0);
    vec("br_after_freeze", 1'b1, OP_RTYPE, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 4'hF, 2'b11, PC_BRANCH, 1'b0, 4'd4, 4'd0);
    idle("after_freeze_br", 1'b0, 4'd4, 4'd1);

    // Memory timeout after 8 frozen cycles, sticky, then reset mid-wait
    rstv("reset3");
    idle("release3", 1'b0, 4'd0, 4'd0);
    for (int k = 0; k < 8; k++) freezev($sformatf("wait%0d", k), 1'b0, 1'b0, 4'(k), 4'd0);
    freezev("mem_err_set", 1'b0, 1'b1, 4'd8, 4'd0);
    freezev("mem_err_sticky", 1'b0, 1'b1, 4'd9, 4'd0);
    vec("rst_mid_wait", 1'b0, OP_RTYPE, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 4'h0, 2'b11, PC_SEQ, 1'b0, 4'd0, 4'd0);
    idle("release_after_wait", 1'b0, 4'd0, 4'd0);

    // Reset in the middle of a load-use stall leaves no residual stall
    vec("lu_then_rst", 1'b1, OP_RTYPE, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1, 4'b0011, 2'b01, PC_SEQ, 1'b0, 4'd0, 4'd0);
    rstv("rst_mid_lu");
    idle("no_residual1", 1'b0, 4'd0, 4'd0);
    idle("no_residual2", 1'b0, 4'd0, 4'd0);

    // 2^4+5 back-to-back stall cycles: stall_cycles saturates at 15
    for (int k = 0; k < 21; k++)
      vec($sformatf("sat%0d", k), 1'b1, OP_RTYPE, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1,
          4'b0011, 2'b01, PC_SEQ, 1'b0, (k < 15) ? 4'(k) : 4'd15, 4'd0);
    idle("sat_hold", 1'b0, 4'd15, 4'd0);

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
